// File: rtl/addertree_reduce_ctrl.sv
// Sequences a long signed-vector reduction through one shared combinational AdderTree,
// accumulating registered chunk sums and returning a full-width and a saturated total.
module addertree_reduce_ctrl #(
  parameter int ELEMENTS   = 8,
  parameter int WIDTH      = 8,
  parameter int TREE_W     = WIDTH + $clog2(ELEMENTS),
  parameter int MAX_CHUNKS = 256,
  parameter int ACC_W      = 24
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                start_in,
  input  logic [$clog2(MAX_CHUNKS+1)-1:0]     num_chunks_in,
  output logic                                busy_out,
  input  logic [ELEMENTS-1:0][WIDTH-1:0]      chunk_in,
  input  logic                                chunk_valid_in,
  output logic                                chunk_ready_out,
  output logic [ELEMENTS-1:0][TREE_W-1:0]     tree_vec_out,
  input  logic [TREE_W-1:0]                   tree_sum_in,
  output logic                                result_valid_out,
  input  logic                                result_ready_in,
  output logic [ACC_W-1:0]                    result_out,
  output logic [WIDTH-1:0]                    result_sat_out,
  output logic                                sat_flag_out
);

  localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]                       state_q, state_d;
  logic [ACC_W-1:0]                 acc_q, acc_d;
  logic [CNT_W-1:0]                 remaining_q, remaining_d;
  logic                             stage_valid_q, stage_valid_d;
  logic [ELEMENTS-1:0][TREE_W-1:0]  tree_vec_q, tree_vec_d;
  logic [CNT_W-1:0]                 num_clamped;
  logic                             sat_hi, sat_lo;

  assign num_clamped = (num_chunks_in > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS) : num_chunks_in;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    remaining_d   = remaining_q;
    stage_valid_d = 1'b0;
    tree_vec_d    = tree_vec_q;

    // The tree output always belongs to the chunk registered on the previous handshake.
    if (stage_valid_q) begin
      acc_d = acc_q + {{(ACC_W-TREE_W){tree_sum_in[TREE_W-1]}}, tree_sum_in};
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          acc_d = '0;
          if (num_clamped == '0) begin
            state_d = S_DONE;
          end else begin
            remaining_d = num_clamped;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (chunk_valid_in) begin
          for (int i = 0; i < ELEMENTS; i++) begin
            tree_vec_d[i] = {{(TREE_W-WIDTH){chunk_in[i][WIDTH-1]}}, chunk_in[i]};
          end
          stage_valid_d = 1'b1;
          remaining_d   = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (result_ready_in) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      remaining_q   <= '0;
      stage_valid_q <= 1'b0;
      tree_vec_q    <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      remaining_q   <= remaining_d;
      stage_valid_q <= stage_valid_d;
      tree_vec_q    <= tree_vec_d;
    end
  end

  always_comb begin
    sat_hi = $signed(acc_q) > SAT_MAX;
    sat_lo = $signed(acc_q) < SAT_MIN;
    if (sat_hi) begin
      result_sat_out = SAT_MAX[WIDTH-1:0];
    end else if (sat_lo) begin
      result_sat_out = SAT_MIN[WIDTH-1:0];
    end else begin
      result_sat_out = acc_q[WIDTH-1:0];
    end
  end

  assign sat_flag_out     = sat_hi | sat_lo;
  assign result_out       = acc_q;
  assign tree_vec_out     = tree_vec_q;
  assign busy_out         = (state_q != S_IDLE);
  assign chunk_ready_out  = (state_q == S_RUN);
  assign result_valid_out = (state_q == S_DONE);

endmodule

// File: tb/tb_addertree_reduce_ctrl.sv
// Table-driven and randomized bench for addertree_reduce_ctrl, with a behavioural adder tree
// and a plain-arithmetic sum/clamp model of the whole reduction.
module tb_addertree_reduce_ctrl;

  localparam int ELEMENTS   = 8;
  localparam int WIDTH      = 8;
  localparam int TREE_W     = WIDTH + $clog2(ELEMENTS);
  localparam int MAX_CHUNKS = 256;
  localparam int ACC_W      = 24;
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 1);
  localparam int BUDGET     = 50;

  typedef struct {
    int     num;
    int     fill;
    bit     rnd;
    int     gap;
    int     hold;
    longint exp_res;
    longint exp_sat;
    longint exp_flag;
  } vec_t;

  logic                            clk_in = 1'b0;
  logic                            rst_n_in;
  logic                            start_in;
  logic [CNT_W-1:0]                num_chunks_in;
  logic                            busy_out;
  logic [ELEMENTS-1:0][WIDTH-1:0]  chunk_in;
  logic                            chunk_valid_in;
  logic                            chunk_ready_out;
  logic [ELEMENTS-1:0][TREE_W-1:0] tree_vec_out;
  logic [TREE_W-1:0]               tree_sum_in;
  logic                            result_valid_out;
  logic                            result_ready_in;
  logic [ACC_W-1:0]                result_out;
  logic [WIDTH-1:0]                result_sat_out;
  logic                            sat_flag_out;

  int     checks_total  = 0;
  int     checks_passed = 0;
  longint cycle         = 0;
  longint hs_count      = 0;

  addertree_reduce_ctrl #(
    .ELEMENTS(ELEMENTS), .WIDTH(WIDTH), .TREE_W(TREE_W), .MAX_CHUNKS(MAX_CHUNKS), .ACC_W(ACC_W)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .num_chunks_in(num_chunks_in),
    .busy_out(busy_out), .chunk_in(chunk_in), .chunk_valid_in(chunk_valid_in),
    .chunk_ready_out(chunk_ready_out), .tree_vec_out(tree_vec_out), .tree_sum_in(tree_sum_in),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_out(result_out), .result_sat_out(result_sat_out), .sat_flag_out(sat_flag_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural stand-in for the shared AdderTree instance.
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < ELEMENTS; i++) s += int'($signed(tree_vec_out[i]));
    tree_sum_in = TREE_W'(s);
  end

  always @(posedge clk_in) begin
    cycle <= cycle + 1;
    if (rst_n_in && chunk_valid_in && chunk_ready_out) hs_count <= hs_count + 1;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Starts a reduction, feeds the clamped number of chunks and waits for the result.
  task automatic applyStimulus(input vec_t v, output longint total, output int fed,
                               output longint lat, output longint acc_cycles);
    longint start_cycle, last_cycle;
    int budget;
    total = 0;
    fed   = (v.num > MAX_CHUNKS) ? MAX_CHUNKS : v.num;
    start_in      = 1'b1;
    num_chunks_in = CNT_W'(v.num);
    tick();
    start_in    = 1'b0;
    start_cycle = cycle;
    last_cycle  = cycle;
    for (int c = 0; c < fed; c++) begin
      chunk_valid_in = 1'b0;
      repeat (v.gap) tick();
      for (int e = 0; e < ELEMENTS; e++) begin
        chunk_in[e] = v.rnd ? WIDTH'($urandom_range(0, 255)) : WIDTH'(v.fill);
        total += longint'($signed(chunk_in[e]));
      end
      chunk_valid_in = 1'b1;
      budget = BUDGET;
      while (!chunk_ready_out && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) begin
        checkOutput("chunk_ready_timeout", 0, 1);
        break;
      end
      tick();
      last_cycle = cycle;
    end
    chunk_valid_in = 1'b0;
    acc_cycles = last_cycle - start_cycle;
    budget = BUDGET;
    while (!result_valid_out && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) checkOutput("result_valid_timeout", 0, 1);
    lat = cycle - last_cycle;
  endtask

  task automatic runVector(input string tag, input vec_t v);
    longint total, lat, acc_cycles, hs_base, exp_res, exp_sat, exp_flag, held;
    int fed;
    hs_base = hs_count;
    applyStimulus(v, total, fed, lat, acc_cycles);
    if (v.rnd) begin
      exp_res  = total;
      exp_sat  = (total > 127) ? 127 : ((total < -128) ? -128 : total);
      exp_flag = (total > 127 || total < -128) ? 1 : 0;
    end else begin
      exp_res  = v.exp_res;
      exp_sat  = v.exp_sat;
      exp_flag = v.exp_flag;
    end
    checkOutput({tag, "_result"}, longint'($signed(result_out)), exp_res);
    checkOutput({tag, "_sat"}, longint'($signed(result_sat_out)), exp_sat);
    checkOutput({tag, "_flag"}, longint'(sat_flag_out), exp_flag);
    checkOutput({tag, "_latency"}, lat, (fed > 0) ? 1 : 0);
    if (v.gap == 0 && fed > 0) checkOutput({tag, "_accept_cycles"}, acc_cycles, longint'(fed));
    // Hold the result while poking start and chunk_valid; neither may disturb DONE.
    held = longint'($signed(result_out));
    result_ready_in = 1'b0;
    chunk_valid_in  = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      start_in      = h[0];
      num_chunks_in = CNT_W'(5);
      tick();
    end
    checkOutput({tag, "_held_result"}, longint'($signed(result_out)), held);
    checkOutput({tag, "_held_valid"}, longint'(result_valid_out), 1);
    chunk_valid_in  = 1'b0;
    checkOutput({tag, "_handshakes"}, hs_count - hs_base, longint'(fed));
    start_in        = 1'b1;
    result_ready_in = 1'b1;
    tick();
    start_in        = 1'b0;
    result_ready_in = 1'b0;
    checkOutput({tag, "_valid_drop"}, longint'(result_valid_out), 0);
    checkOutput({tag, "_idle_after"}, longint'(busy_out), 0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, longint'(busy_out), 0);
    checkOutput({tag, "_ready"}, longint'(chunk_ready_out), 0);
    checkOutput({tag, "_valid"}, longint'(result_valid_out), 0);
    checkOutput({tag, "_result"}, longint'(result_out), 0);
    checkOutput({tag, "_sat"}, longint'(result_sat_out), 0);
    checkOutput({tag, "_flag"}, longint'(sat_flag_out), 0);
    checkOutput({tag, "_tree_vec"}, longint'(tree_vec_out == '0), 1);
  endtask

  vec_t table_q[$];

  initial begin
    vec_t v;
    rst_n_in        = 1'b0;
    start_in        = 1'b0;
    num_chunks_in   = '0;
    chunk_in        = '0;
    chunk_valid_in  = 1'b0;
    result_ready_in = 1'b0;

    table_q.push_back('{num: 1,   fill: 1,    rnd: 0, gap: 0, hold: 0, exp_res: 8,     exp_sat: 8,    exp_flag: 0});
    table_q.push_back('{num: 4,   fill: 1,    rnd: 0, gap: 0, hold: 1, exp_res: 32,    exp_sat: 32,   exp_flag: 0});
    table_q.push_back('{num: 2,   fill: -128, rnd: 0, gap: 0, hold: 0, exp_res: -2048, exp_sat: -128, exp_flag: 1});
    table_q.push_back('{num: 0,   fill: 1,    rnd: 0, gap: 0, hold: 2, exp_res: 0,     exp_sat: 0,    exp_flag: 0});
    table_q.push_back('{num: 3,   fill: 5,    rnd: 0, gap: 2, hold: 5, exp_res: 120,   exp_sat: 120,  exp_flag: 0});
    table_q.push_back('{num: 2,   fill: 8,    rnd: 0, gap: 0, hold: 0, exp_res: 128,   exp_sat: 127,  exp_flag: 1});
    table_q.push_back('{num: 2,   fill: -8,   rnd: 0, gap: 1, hold: 0, exp_res: -128,  exp_sat: -128, exp_flag: 0});
    table_q.push_back('{num: 300, fill: 1,    rnd: 0, gap: 0, hold: 0, exp_res: 2048,  exp_sat: 127,  exp_flag: 1});
    for (int r = 0; r < 8; r++) begin
      table_q.push_back('{num: int'($urandom_range(1, 20)), fill: 0, rnd: 1,
                          gap: int'($urandom_range(0, 2)), hold: int'($urandom_range(0, 4)),
                          exp_res: 0, exp_sat: 0, exp_flag: 0});
    end

    repeat (2) @(posedge clk_in);
    #1;
    checkReset("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();

    foreach (table_q[i]) runVector($sformatf("vec%0d", i), table_q[i]);

    // Reset in the middle of a four-chunk run discards everything.
    start_in      = 1'b1;
    num_chunks_in = CNT_W'(4);
    tick();
    start_in       = 1'b0;
    chunk_in       = {ELEMENTS{WIDTH'(1)}};
    chunk_valid_in = 1'b1;
    tick();
    tick();
    chunk_valid_in = 1'b0;
    checkOutput("midrun_busy", longint'(busy_out), 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    checkReset("midrun_reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
    v = '{num: 1, fill: 2, rnd: 0, gap: 0, hold: 0, exp_res: 16, exp_sat: 16, exp_flag: 0};
    runVector("after_reset", v);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
